// File: rtl/yd_reg_wr_arb.sv
`timescale 1ns/1ps
// Register-file write-port arbiter: one-entry hold per requester, up to two writes per cycle.
// Accept-to-we latency 2 cycles; req_ready depends on hold state and grants only, never on req_valid.
module yd_reg_wr_arb #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               we0,
    output logic [AW-1:0]      waddr0,
    output logic [DW-1:0]      din0,
    output logic               we1,
    output logic [AW-1:0]      waddr1,
    output logic [DW-1:0]      din1,
    output logic               jpc,
    output logic [15:0]        conflict_cnt
);

    localparam int          RRW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] ADDR_ZE = '0;
    localparam logic [AW-1:0] ADDR_PC = '1;

    logic [NREQ-1:0] r_hold_v;
    logic [AW-1:0]   r_hold_addr [NREQ];
    logic [DW-1:0]   r_hold_data [NREQ];
    logic [RRW-1:0]  r_rr;
    logic            r_we0;
    logic [AW-1:0]   r_waddr0;
    logic [DW-1:0]   r_din0;
    logic            r_we1;
    logic [AW-1:0]   r_waddr1;
    logic [DW-1:0]   r_din1;
    logic            r_jpc;
    logic [15:0]     r_conflict_cnt;

    logic [NREQ-1:0] w_grant;
    logic            w_p0_vld;
    logic [AW-1:0]   w_p0_addr;
    logic [DW-1:0]   w_p0_data;
    logic            w_p1_vld;
    logic [AW-1:0]   w_p1_addr;
    logic [DW-1:0]   w_p1_data;
    logic            w_clash;
    logic            w_any_grant;
    logic [RRW-1:0]  w_last;
    logic [RRW-1:0]  w_rr_nxt;

    // Scan from rr; addr-0 writes are consumed without a port, same-address holds wait a cycle.
    always_comb begin
        logic [RRW-1:0] v_idx;
        logic           v_take;
        w_grant     = '0;
        w_p0_vld    = 1'b0;
        w_p0_addr   = '0;
        w_p0_data   = '0;
        w_p1_vld    = 1'b0;
        w_p1_addr   = '0;
        w_p1_data   = '0;
        w_clash     = 1'b0;
        w_any_grant = 1'b0;
        w_last      = '0;
        v_idx       = '0;
        v_take      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx  = RRW'((int'(r_rr) + k) % NREQ);
            v_take = 1'b0;
            if (r_hold_v[v_idx] && !flush) begin
                if (r_hold_addr[v_idx] == ADDR_ZE) begin
                    v_take = 1'b1;
                end else if (!w_p0_vld) begin
                    w_p0_vld  = 1'b1;
                    w_p0_addr = r_hold_addr[v_idx];
                    w_p0_data = r_hold_data[v_idx];
                    v_take    = 1'b1;
                end else if (!w_p1_vld && (r_hold_addr[v_idx] != w_p0_addr)) begin
                    w_p1_vld  = 1'b1;
                    w_p1_addr = r_hold_addr[v_idx];
                    w_p1_data = r_hold_data[v_idx];
                    v_take    = 1'b1;
                end else if ((r_hold_addr[v_idx] == w_p0_addr) ||
                             (w_p1_vld && (r_hold_addr[v_idx] == w_p1_addr))) begin
                    w_clash = 1'b1;
                end
            end
            if (v_take) begin
                w_grant[v_idx] = 1'b1;
                w_any_grant    = 1'b1;
                w_last         = v_idx;
            end
        end
    end

    assign w_rr_nxt  = (int'(w_last) == NREQ - 1) ? '0 : w_last + 1'b1;
    assign req_ready = rst_n ? ((~r_hold_v | w_grant) & {NREQ{~flush}}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v       <= '0;
            r_rr           <= '0;
            r_we0          <= 1'b0;
            r_waddr0       <= '0;
            r_din0         <= '0;
            r_we1          <= 1'b0;
            r_waddr1       <= '0;
            r_din1         <= '0;
            r_jpc          <= 1'b0;
            r_conflict_cnt <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_hold_addr[i] <= '0;
                r_hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush) begin
                    r_hold_v[i] <= 1'b0;
                end else if (req_valid[i] && req_ready[i]) begin
                    r_hold_v[i]    <= 1'b1;
                    r_hold_addr[i] <= req_addr[i*AW +: AW];
                    r_hold_data[i] <= req_data[i*DW +: DW];
                end else if (w_grant[i]) begin
                    r_hold_v[i] <= 1'b0;
                end
            end
            if (w_any_grant) begin
                r_rr <= w_rr_nxt;
            end
            r_we0 <= w_p0_vld;
            r_we1 <= w_p1_vld;
            if (w_p0_vld) begin
                r_waddr0 <= w_p0_addr;
                r_din0   <= w_p0_data;
            end
            if (w_p1_vld) begin
                r_waddr1 <= w_p1_addr;
                r_din1   <= w_p1_data;
            end
            r_jpc <= (w_p0_vld && (w_p0_addr == ADDR_PC)) || (w_p1_vld && (w_p1_addr == ADDR_PC));
            if (w_clash && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign we0          = r_we0;
    assign waddr0       = r_waddr0;
    assign din0         = r_din0;
    assign we1          = r_we1;
    assign waddr1       = r_waddr1;
    assign din1         = r_din1;
    assign jpc          = r_jpc;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_yd_reg_wr_arb.sv
`timescale 1ns/1ps
// Directed bench for yd_reg_wr_arb: vector table for single-shot requests plus flush, saturation and reset sequences.
module tb_yd_reg_wr_arb;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        we0;
    logic [3:0]  waddr0;
    logic [15:0] din0;
    logic        we1;
    logic [3:0]  waddr1;
    logic [15:0] din1;
    logic        jpc;
    logic [15:0] conflict_cnt;

    int tests;
    int fails;

    yd_reg_wr_arb #(.NREQ(3), .DW(16), .AW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .we0         (we0),
        .waddr0      (waddr0),
        .din0        (din0),
        .we1         (we1),
        .waddr1      (waddr1),
        .din1        (din1),
        .jpc         (jpc),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we0;
        logic [3:0]  wa0;
        logic [15:0] dn0;
        logic        we1;
        logic [3:0]  wa1;
        logic [15:0] dn1;
        logic        jpc;
        logic [15:0] cnt;
    } snap_t;

    typedef struct packed {
        logic [2:0]  vld;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic [3:0]  a2;
        logic [15:0] d2;
        snap_t       k0;
        snap_t       k1;
    } vec_t;

    vec_t vecs [9];

    function automatic snap_t sn(input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                                 input logic w1, input logic [3:0] a1, input logic [15:0] d1,
                                 input logic j, input logic [15:0] c);
        snap_t s;
        s.we0 = w0; s.wa0 = a0; s.dn0 = d0;
        s.we1 = w1; s.wa1 = a1; s.dn1 = d1;
        s.jpc = j;  s.cnt = c;
        return s;
    endfunction

    function automatic snap_t idle(input logic [15:0] c);
        return sn(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, c);
    endfunction

    function automatic vec_t mv(input logic [2:0] v,
                                input logic [3:0] a0, input logic [15:0] d0,
                                input logic [3:0] a1, input logic [15:0] d1,
                                input logic [3:0] a2, input logic [15:0] d2,
                                input snap_t k0, input snap_t k1);
        vec_t r;
        r.vld = v;
        r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.a2 = a2; r.d2 = d2;
        r.k0 = k0; r.k1 = k1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_snap(input string tag, input snap_t s);
        chk({tag, ".we0"}, 32'(we0), 32'(s.we0));
        chk({tag, ".we1"}, 32'(we1), 32'(s.we1));
        chk({tag, ".jpc"}, 32'(jpc), 32'(s.jpc));
        chk({tag, ".cnt"}, 32'(conflict_cnt), 32'(s.cnt));
        if (s.we0) begin
            chk({tag, ".waddr0"}, 32'(waddr0), 32'(s.wa0));
            chk({tag, ".din0"}, 32'(din0), 32'(s.dn0));
        end
        if (s.we1) begin
            chk({tag, ".waddr1"}, 32'(waddr1), 32'(s.wa1));
            chk({tag, ".din1"}, 32'(din1), 32'(s.dn1));
        end
    endtask

    task automatic drive(input logic [2:0] v,
                         input logic [3:0] a0, input logic [15:0] d0,
                         input logic [3:0] a1, input logic [15:0] d1,
                         input logic [3:0] a2, input logic [15:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        // rr walks 0 -> 1 -> 0 -> 2 -> 2 -> 0 -> 2 -> 2 -> 2 -> 2 across these vectors
        vecs[0] = mv(3'b001, 4'd2, 16'h1234, 4'd0, 16'h0, 4'd0, 16'h0,
                     sn(1, 4'd2, 16'h1234, 0, 4'd0, 16'h0, 0, 16'd0), idle(16'd0));
        vecs[1] = mv(3'b100, 4'd0, 16'h0, 4'd0, 16'h0, 4'd15, 16'h0040,
                     sn(1, 4'd15, 16'h0040, 0, 4'd0, 16'h0, 1, 16'd0), idle(16'd0));
        vecs[2] = mv(3'b011, 4'd3, 16'hAAAA, 4'd4, 16'hBBBB, 4'd0, 16'h0,
                     sn(1, 4'd3, 16'hAAAA, 1, 4'd4, 16'hBBBB, 0, 16'd0), idle(16'd0));
        vecs[3] = mv(3'b111, 4'd0, 16'hDEAD, 4'd6, 16'h0001, 4'd7, 16'h0002,
                     sn(1, 4'd7, 16'h0002, 1, 4'd6, 16'h0001, 0, 16'd0), idle(16'd0));
        vecs[4] = mv(3'b100, 4'd0, 16'h0, 4'd0, 16'h0, 4'd9, 16'h0099,
                     sn(1, 4'd9, 16'h0099, 0, 4'd0, 16'h0, 0, 16'd0), idle(16'd0));
        vecs[5] = mv(3'b011, 4'd5, 16'h0011, 4'd5, 16'h0022, 4'd0, 16'h0,
                     sn(1, 4'd5, 16'h0011, 0, 4'd0, 16'h0, 0, 16'd1),
                     sn(1, 4'd5, 16'h0022, 0, 4'd0, 16'h0, 0, 16'd1));
        vecs[6] = mv(3'b011, 4'd15, 16'h0100, 4'd15, 16'h0200, 4'd0, 16'h0,
                     sn(1, 4'd15, 16'h0100, 0, 4'd0, 16'h0, 1, 16'd2),
                     sn(1, 4'd15, 16'h0200, 0, 4'd0, 16'h0, 1, 16'd2));
        vecs[7] = mv(3'b111, 4'd1, 16'h0A01, 4'd2, 16'h0A02, 4'd3, 16'h0A03,
                     sn(1, 4'd3, 16'h0A03, 1, 4'd1, 16'h0A01, 0, 16'd2),
                     sn(1, 4'd2, 16'h0A02, 0, 4'd0, 16'h0, 0, 16'd2));
        vecs[8] = mv(3'b111, 4'd8, 16'h0B00, 4'd8, 16'h0B01, 4'd10, 16'h0B02,
                     sn(1, 4'd10, 16'h0B02, 1, 4'd8, 16'h0B00, 0, 16'd3),
                     sn(1, 4'd8, 16'h0B01, 0, 4'd0, 16'h0, 0, 16'd3));

        rst_n = 1'b0;
        flush = 1'b0;
        drive(3'b000, 4'd0, 16'h0, 4'd0, 16'h0, 4'd0, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'h0);
        chk_snap("rst", idle(16'd0));
        chk("rst.waddr0", 32'(waddr0), 32'h0);
        chk("rst.din0", 32'(din0), 32'h0);
        chk("rst.waddr1", 32'(waddr1), 32'h0);
        chk("rst.din1", 32'(din1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.req_ready", 32'(req_ready), 32'h7);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].vld, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1, vecs[i].a2, vecs[i].d2);
            @(negedge clk);
            req_valid = 3'b000;
            @(negedge clk);
            chk_snap($sformatf("v%0d.k0", i), vecs[i].k0);
            @(negedge clk);
            chk_snap($sformatf("v%0d.k1", i), vecs[i].k1);
            @(negedge clk);
        end

        // Three same-address holds: only the rr-first one is granted, the others back-pressure.
        drive(3'b111, 4'd12, 16'h0C00, 4'd12, 16'h0C01, 4'd12, 16'h0C02);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("fill.req_ready", 32'(req_ready), 32'h4);
        flush = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("flush.req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 3'b000;
        chk_snap("flush.next", idle(16'd3));
        #1;
        chk("flush.req_ready_after", 32'(req_ready), 32'h7);
        @(negedge clk);
        chk_snap("flush.drained", idle(16'd3));
        chk("hold.waddr0", 32'(waddr0), 32'h8);
        chk("hold.din0", 32'(din0), 32'h0B01);
        chk("hold.waddr1", 32'(waddr1), 32'h8);
        chk("hold.din1", 32'(din1), 32'h0B00);

        // rr must still be 2 after the flush, so requester 2 takes port 0.
        drive(3'b101, 4'd1, 16'h0D00, 4'd0, 16'h0, 4'd2, 16'h0D02);
        @(negedge clk);
        req_valid = 3'b000;
        @(negedge clk);
        chk_snap("rr_keep", sn(1, 4'd2, 16'h0D02, 1, 4'd1, 16'h0D00, 0, 16'd3));
        @(negedge clk);

        drive(3'b011, 4'd5, 16'h5500, 4'd5, 16'h5501, 4'd0, 16'h0);
        repeat (65600) @(negedge clk);
        chk("sat.cnt", 32'(conflict_cnt), 32'hFFFF);
        req_valid = 3'b000;
        repeat (4) @(negedge clk);
        chk("sat.cnt_hold", 32'(conflict_cnt), 32'hFFFF);
        chk("sat.idle_we0", 32'(we0), 32'h0);

        drive(3'b001, 4'd11, 16'h0E00, 4'd0, 16'h0, 4'd0, 16'h0);
        @(negedge clk);
        req_valid = 3'b000;
        rst_n = 1'b0;
        #1;
        chk("midrst.we0", 32'(we0), 32'h0);
        chk("midrst.cnt", 32'(conflict_cnt), 32'h0);
        chk("midrst.req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midrst.no_we0_%0d", c), 32'(we0), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
